// File: rtl/shift_pkg.sv
// Shared encodings and width helpers for the iterative shifter.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_LSR = 2'd0,
    SH_ASR = 2'd1,
    SH_ROR = 2'd2,
    SH_RRX = 2'd3
  } mode_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  function automatic int dist_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Per-step amount must be able to represent STEP itself.
  function automatic int amt_w(input int step);
    return $clog2(step) + 1;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One enabled cycle of shifting: moves a {C,data} word by 0..STEP bits.
// With SHIFT_STICKY_EN, also reports the OR of bits dropped in lsr/asr modes.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int AW    = amt_w(STEP)
) (
  input  logic [WIDTH-1:0] data,
  input  logic             c,
  input  logic [AW-1:0]    amt,
  input  mode_t            mode,
  input  logic             dir,
  output logic [WIDTH-1:0] data_n,
  output logic             c_n
`ifdef SHIFT_STICKY_EN
  ,
  output logic             sticky
`endif
);

  logic bit_out;
  logic fill;

  // Chain of single-bit moves; the carry always tracks the bit that left the word.
  always_comb begin
    data_n  = data;
    c_n     = c;
    bit_out = 1'b0;
    fill    = 1'b0;
`ifdef SHIFT_STICKY_EN
    sticky  = 1'b0;
`endif
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(amt)) begin
        if (dir == DIR_LEFT) begin
          bit_out = data_n[WIDTH-1];
          case (mode)
            SH_ROR:  fill = data_n[WIDTH-1];
            SH_RRX:  fill = c_n;
            default: fill = 1'b0;
          endcase
          data_n = {data_n[WIDTH-2:0], fill};
        end else begin
          bit_out = data_n[0];
          case (mode)
            SH_LSR:  fill = 1'b0;
            SH_ASR:  fill = data_n[WIDTH-1];
            SH_ROR:  fill = data_n[0];
            SH_RRX:  fill = c_n;
            default: fill = 1'b0;
          endcase
          data_n = {fill, data_n[WIDTH-1:1]};
        end
        c_n = bit_out;
`ifdef SHIFT_STICKY_EN
        sticky = sticky | (bit_out & ((mode == SH_LSR) || (mode == SH_ASR)));
`endif
      end
    end
  end

endmodule

// File: rtl/shift_unit_iter.sv
// Multi-cycle shifter with START/BUSY/DONE handshake, up to STEP bits per tick.
// Define SHIFT_STICKY_EN to add the STICKY output for FP rounding.
module shift_unit_iter
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic [4:0]               LOGISIM_CLOCK_TREE_0,
  input  logic                     RESET,
  input  logic                     START,
  input  logic [WIDTH-1:0]         OP_IN,
  input  logic [dist_w(WIDTH)-1:0] SHIFT_DISTANCE,
  input  logic [1:0]               SHIFT_FUNC_SEL,
  input  logic                     DIR,
  input  logic                     CIN,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [WIDTH-1:0]         RESULT,
  output logic                     COUT
`ifdef SHIFT_STICKY_EN
  ,
  output logic                     STICKY
`endif
);

  localparam int DW = dist_w(WIDTH);
  localparam int AW = amt_w(STEP);

  logic clk, tick;
  logic unused_clk_bits;
  assign clk  = LOGISIM_CLOCK_TREE_0[4];
  assign tick = LOGISIM_CLOCK_TREE_0[2];
  assign unused_clk_bits = ^{LOGISIM_CLOCK_TREE_0[3], LOGISIM_CLOCK_TREE_0[1:0]};

  state_t            state, state_n;
  logic [DW-1:0]     rem;
  logic [WIDTH-1:0]  data, res;
  logic              carry, cout_r;
  mode_t             mode;
  logic              dir;

  logic              accept, last;
  logic [AW-1:0]     amt;
  logic [WIDTH-1:0]  step_data;
  logic              step_c;
`ifdef SHIFT_STICKY_EN
  logic              step_sticky, sticky_acc, sticky_r;
`endif

  assign accept = START && ((state == S_IDLE) || (state == S_DONE));
  assign amt    = (int'(rem) < STEP) ? AW'(rem) : AW'(STEP);
  assign last   = (rem == DW'(amt));

  shift_step #(.WIDTH(WIDTH), .STEP(STEP), .AW(AW)) u_step (
    .data   (data),
    .c      (carry),
    .amt    (amt),
    .mode   (mode),
    .dir    (dir),
    .data_n (step_data),
    .c_n    (step_c)
`ifdef SHIFT_STICKY_EN
    ,
    .sticky (step_sticky)
`endif
  );

  always_ff @(posedge clk) begin
    if (tick) begin
      if (RESET) state <= S_IDLE;
      else       state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (START) state_n = (SHIFT_DISTANCE == '0) ? S_DONE : S_SHIFT;
        else       state_n = S_IDLE;
      end
      S_SHIFT: if (last) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  // RESULT/COUT only change when an operation completes, so they hold through SHIFT.
  always_ff @(posedge clk) begin
    if (tick) begin
      if (RESET) begin
        data   <= '0;
        carry  <= 1'b0;
        rem    <= '0;
        mode   <= SH_LSR;
        dir    <= DIR_RIGHT;
        res    <= '0;
        cout_r <= 1'b0;
`ifdef SHIFT_STICKY_EN
        sticky_acc <= 1'b0;
        sticky_r   <= 1'b0;
`endif
      end else if (accept) begin
        data  <= OP_IN;
        carry <= CIN;
        rem   <= SHIFT_DISTANCE;
        mode  <= mode_t'(SHIFT_FUNC_SEL);
        dir   <= DIR;
`ifdef SHIFT_STICKY_EN
        sticky_acc <= 1'b0;
`endif
        if (SHIFT_DISTANCE == '0) begin
          res    <= OP_IN;
          cout_r <= CIN;
`ifdef SHIFT_STICKY_EN
          sticky_r <= 1'b0;
`endif
        end
      end else if (state == S_SHIFT) begin
        data  <= step_data;
        carry <= step_c;
        rem   <= rem - DW'(amt);
`ifdef SHIFT_STICKY_EN
        sticky_acc <= sticky_acc | step_sticky;
`endif
        if (last) begin
          res    <= step_data;
          cout_r <= step_c;
`ifdef SHIFT_STICKY_EN
          sticky_r <= sticky_acc | step_sticky;
`endif
        end
      end
    end
  end

  assign BUSY   = (state == S_SHIFT);
  assign DONE   = (state == S_DONE);
  assign RESULT = res;
  assign COUT   = cout_r;
`ifdef SHIFT_STICKY_EN
  assign STICKY = sticky_r;
`endif

endmodule
